mem_access_unit: RTL and testbench

- Memory-stage responder for the EX→EXMEM load/store request interface.
- Accepts one registered request per transaction: enable, write-enable, address, store data, opcode, funct3, rd.
- Drives a word-wide data-bus handshake (req/gnt, then rvalid for loads).
- Aligns and extends load data, then issues the register-file writeback. Stalls the control unit while a transaction is outstanding.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_access_unit_load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access unit: RISC-V load/store encodings,
// enable/disable literals and the size/alignment legality helper.
package mem_access_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG  = 5'd0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // True when funct3 names a real access of this direction and the byte
  // address is naturally aligned for that access size.
  function automatic logic accessLegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addrLow);
    logic ok;
    ok = DISABLE;
    case (funct3)
      F3_LB:   ok = ENABLE;
      F3_LH:   ok = ~addrLow[0];
      F3_LW:   ok = (addrLow == 2'b00);
      F3_LBU:  ok = ~we;
      F3_LHU:  ok = ~we & ~addrLow[0];
      default: ok = DISABLE;
    endcase
    return ok;
  endfunction

  // True for the two opcodes that legitimately reach the memory stage.
  function automatic logic isMemOpcode(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to the load funct3.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection followed by extension for the requested load size.
  always_comb begin
    byteSel  = rdata_i[7:0];
    halfSel  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (addr_i)
      2'b00:   byteSel = rdata_i[7:0];
      2'b01:   byteSel = rdata_i[15:8];
      2'b10:   byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    case (funct3_i)
      F3_LB:   result_o = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  result_o = {24'h000000, byteSel};
      F3_LH:   result_o = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  result_o = {16'h0000, halfSel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage responder: takes one load/store from the EXMEM register,
// runs the req/gnt (+rvalid) bus handshake with a wait timeout, and issues
// the aligned, extended load result as a one-cycle register writeback.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exmem2mem_valid_i,
  input  logic              exmem2mem_mem_en_i,
  input  logic              exmem2mem_we_i,
  input  logic [ADDR_W-1:0] exmem2mem_addr_i,
  input  logic [31:0]       exmem2mem_data_i,
  input  logic [6:0]        exmem2mem_opcode_i,
  input  logic [2:0]        exmem2mem_funct3_i,
  input  logic [4:0]        exmem2mem_rd_i,
  output logic              mem2exmem_ready_o,
  output logic              mem2cu_stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              mem2regs_wb_en_o,
  output logic [4:0]        mem2regs_rd_addr_o,
  output logic [31:0]       mem2regs_rd_data_o,
  output logic              mem2cu_misalign_o,
  output logic              mem2cu_timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    waitCnt_q;
  logic [4:0]          rd_q;
  logic [2:0]          funct3_q;
  logic [1:0]          addrLow_q;
  logic                ready_q;
  logic                stall_q;
  logic                busReq_q;
  logic                busWe_q;
  logic [ADDR_W-1:0]   busAddr_q;
  logic [3:0]          busBe_q;
  logic [31:0]         busWdata_q;
  logic                wbEn_q;
  logic [4:0]          rdAddr_q;
  logic [31:0]         rdData_q;
  logic                misalign_q;
  logic                timeout_q;

  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic                accessOk_d;
  logic [31:0]         loadResult;
  logic                accept;

  // The opcode travels with the request for tracing only; direction comes from we.
  logic unusedOpcode;
  assign unusedOpcode = isMemOpcode(exmem2mem_opcode_i);

  assign accept = exmem2mem_valid_i & exmem2mem_mem_en_i;

  // Byte-lane enables, replicated store data and legality for the incoming request.
  always_comb begin
    be_d       = BE_WORD;
    wdata_d    = exmem2mem_data_i;
    accessOk_d = accessLegal(exmem2mem_we_i, exmem2mem_funct3_i, exmem2mem_addr_i[1:0]);
    case (exmem2mem_funct3_i)
      F3_SB, F3_LBU: begin
        be_d    = BE_BYTE << exmem2mem_addr_i[1:0];
        wdata_d = {4{exmem2mem_data_i[7:0]}};
      end
      F3_SH, F3_LHU: begin
        be_d    = BE_HALF << exmem2mem_addr_i[1:0];
        wdata_d = {2{exmem2mem_data_i[15:0]}};
      end
      F3_SW:   be_d = BE_WORD;
      default: be_d = BE_WORD;
    endcase
  end

  mem_access_unit_load_align u_load_align (
    .rdata_i  (bus_rdata_i),
    .addr_i   (addrLow_q),
    .funct3_i (funct3_q),
    .result_o (loadResult)
  );

  // Transaction FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waitCnt_q  <= '0;
      rd_q       <= ZERO_REG;
      funct3_q   <= 3'b000;
      addrLow_q  <= 2'b00;
      ready_q    <= ENABLE;
      stall_q    <= DISABLE;
      busReq_q   <= DISABLE;
      busWe_q    <= DISABLE;
      busAddr_q  <= '0;
      busBe_q    <= 4'b0000;
      busWdata_q <= ZERO_WORD;
      wbEn_q     <= DISABLE;
      rdAddr_q   <= ZERO_REG;
      rdData_q   <= ZERO_WORD;
      misalign_q <= DISABLE;
      timeout_q  <= DISABLE;
    end else begin
      wbEn_q     <= DISABLE;
      misalign_q <= DISABLE;
      timeout_q  <= DISABLE;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rd_q      <= exmem2mem_rd_i;
            funct3_q  <= exmem2mem_funct3_i;
            addrLow_q <= exmem2mem_addr_i[1:0];
            ready_q   <= DISABLE;
            if (accessOk_d) begin
              state_q    <= ST_REQ;
              waitCnt_q  <= '0;
              stall_q    <= ENABLE;
              busReq_q   <= ENABLE;
              busWe_q    <= exmem2mem_we_i;
              busAddr_q  <= {exmem2mem_addr_i[ADDR_W-1:2], 2'b00};
              busBe_q    <= be_d;
              busWdata_q <= wdata_d;
            end else begin
              state_q    <= ST_DONE;
              misalign_q <= ENABLE;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            busReq_q  <= DISABLE;
            waitCnt_q <= '0;
            if (busWe_q) begin
              state_q <= ST_DONE;
              stall_q <= DISABLE;
            end else begin
              state_q <= ST_RESP;
            end
          end else if (waitCnt_q == CNT_LAST) begin
            state_q   <= ST_DONE;
            busReq_q  <= DISABLE;
            stall_q   <= DISABLE;
            timeout_q <= ENABLE;
          end else begin
            waitCnt_q <= waitCnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus_rvalid_i) begin
            state_q <= ST_DONE;
            stall_q <= DISABLE;
            if (rd_q != ZERO_REG) begin
              wbEn_q   <= ENABLE;
              rdAddr_q <= rd_q;
              rdData_q <= loadResult;
            end
          end else if (waitCnt_q == CNT_LAST) begin
            state_q   <= ST_DONE;
            stall_q   <= DISABLE;
            timeout_q <= ENABLE;
          end else begin
            waitCnt_q <= waitCnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= ENABLE;
        end
      endcase
    end
  end

  assign mem2exmem_ready_o  = ready_q;
  assign mem2cu_stall_o     = stall_q;
  assign bus_req_o          = busReq_q;
  assign bus_we_o           = busWe_q;
  assign bus_addr_o         = busAddr_q;
  assign bus_be_o           = busBe_q;
  assign bus_wdata_o        = busWdata_q;
  assign mem2regs_wb_en_o   = wbEn_q;
  assign mem2regs_rd_addr_o = rdAddr_q;
  assign mem2regs_rd_data_o = rdData_q;
  assign mem2cu_misalign_o  = misalign_q;
  assign mem2cu_timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads of every size, a replicated
// byte store, misaligned/illegal requests, bus timeout and mid-flight reset.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        memEn;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        ready;
  logic        stall;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busGnt;
  logic        busRvalid;
  logic [31:0] busRdata;
  logic        wbEn;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        misalign;
  logic        timeout;

  int compared;
  int mismatched;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .exmem2mem_valid_i  (valid),
    .exmem2mem_mem_en_i (memEn),
    .exmem2mem_we_i     (we),
    .exmem2mem_addr_i   (addr),
    .exmem2mem_data_i   (data),
    .exmem2mem_opcode_i (opcode),
    .exmem2mem_funct3_i (funct3),
    .exmem2mem_rd_i     (rd),
    .mem2exmem_ready_o  (ready),
    .mem2cu_stall_o     (stall),
    .bus_req_o          (busReq),
    .bus_we_o           (busWe),
    .bus_addr_o         (busAddr),
    .bus_be_o           (busBe),
    .bus_wdata_o        (busWdata),
    .bus_gnt_i          (busGnt),
    .bus_rvalid_i       (busRvalid),
    .bus_rdata_i        (busRdata),
    .mem2regs_wb_en_o   (wbEn),
    .mem2regs_rd_addr_o (rdAddr),
    .mem2regs_rd_data_o (rdData),
    .mem2cu_misalign_o  (misalign),
    .mem2cu_timeout_o   (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic isStore, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input logic [4:0] r);
    valid  = 1'b1;
    memEn  = 1'b1;
    we     = isStore;
    addr   = a;
    data   = d;
    funct3 = f3;
    rd     = r;
    opcode = isStore ? 7'b0100011 : 7'b0000011;
    @(negedge clk);
    valid  = 1'b0;
    memEn  = 1'b0;
  endtask

  // Minimum-latency load: gnt in cycle 1, rvalid in cycle 2, writeback in cycle 3.
  task automatic doLoad(input string tag, input logic [31:0] a, input logic [2:0] f3,
                        input logic [4:0] r, input logic [31:0] rdat, input logic [3:0] expBe,
                        input logic expWb, input logic [31:0] expData);
    applyStimulus(1'b0, a, 32'h0, f3, r);
    checkOutput({tag, "_req"}, busReq, 1);
    checkOutput({tag, "_addr"}, busAddr, a & 32'hFFFF_FFFC);
    checkOutput({tag, "_be"}, busBe, expBe);
    checkOutput({tag, "_stall"}, stall, 1);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    checkOutput({tag, "_resp_req"}, busReq, 0);
    busRvalid = 1'b1;
    busRdata  = rdat;
    @(negedge clk);
    busRvalid = 1'b0;
    checkOutput({tag, "_wb_en"}, wbEn, expWb);
    if (expWb) begin
      checkOutput({tag, "_rd_addr"}, rdAddr, r);
      checkOutput({tag, "_rd_data"}, rdData, expData);
    end
    @(negedge clk);
    checkOutput({tag, "_ready"}, ready, 1);
  endtask

  int  reqCycles;
  logic seenTimeout;

  // Directed sequence of transactions with hand-computed expectations.
  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; valid = 1'b0; memEn = 1'b0; we = 1'b0; addr = 32'h0; data = 32'h0;
    opcode = 7'h0; funct3 = 3'h0; rd = 5'h0; busGnt = 1'b0; busRvalid = 1'b0; busRdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_req", busReq, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_wb", wbEn, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Request without mem_en is ignored.
    valid = 1'b1; memEn = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    checkOutput("noen_ready", ready, 1);
    checkOutput("noen_req", busReq, 0);

    doLoad("lw",  32'h100, 3'b010, 5'd5, 32'hDEADBEEF, 4'b1111, 1'b1, 32'hDEADBEEF);
    doLoad("lb",  32'h103, 3'b000, 5'd6, 32'h80FF0000, 4'b1000, 1'b1, 32'hFFFFFF80);
    doLoad("lbu", 32'h103, 3'b100, 5'd6, 32'h80FF0000, 4'b1000, 1'b1, 32'h00000080);
    doLoad("lh",  32'h102, 3'b001, 5'd7, 32'h80FF0000, 4'b1100, 1'b1, 32'hFFFF80FF);
    doLoad("lhu", 32'h102, 3'b101, 5'd7, 32'h80FF0000, 4'b1100, 1'b1, 32'h000080FF);
    doLoad("lb1", 32'h101, 3'b000, 5'd8, 32'h0000_7F00, 4'b0010, 1'b1, 32'h0000007F);
    doLoad("rd0", 32'h100, 3'b010, 5'd0, 32'h12345678, 4'b1111, 1'b0, 32'h0);

    // Byte store with lane replication.
    applyStimulus(1'b1, 32'h201, 32'h000000AB, 3'b000, 5'd0);
    checkOutput("sb_req", busReq, 1);
    checkOutput("sb_we", busWe, 1);
    checkOutput("sb_be", busBe, 4'b0010);
    checkOutput("sb_wdata", busWdata, 32'hABABABAB);
    checkOutput("sb_addr", busAddr, 32'h200);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    checkOutput("sb_done_req", busReq, 0);
    checkOutput("sb_done_wb", wbEn, 0);
    checkOutput("sb_done_stall", stall, 0);
    checkOutput("sb_done_ready", ready, 0);
    @(negedge clk);
    checkOutput("sb_ready", ready, 1);

    // Misaligned word store.
    applyStimulus(1'b1, 32'h102, 32'h11223344, 3'b010, 5'd0);
    checkOutput("sw_mis_pulse", misalign, 1);
    checkOutput("sw_mis_req", busReq, 0);
    checkOutput("sw_mis_wb", wbEn, 0);
    @(negedge clk);
    checkOutput("sw_mis_pulse_end", misalign, 0);
    checkOutput("sw_mis_req2", busReq, 0);
    checkOutput("sw_mis_ready", ready, 1);

    // Misaligned halfword load, illegal load funct3, store with unsigned size.
    applyStimulus(1'b0, 32'h101, 32'h0, 3'b001, 5'd3);
    checkOutput("lh_mis_pulse", misalign, 1);
    checkOutput("lh_mis_req", busReq, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h100, 32'h0, 3'b011, 5'd3);
    checkOutput("f3_011_pulse", misalign, 1);
    @(negedge clk);
    applyStimulus(1'b1, 32'h100, 32'h0, 3'b100, 5'd0);
    checkOutput("sbu_pulse", misalign, 1);
    checkOutput("sbu_req", busReq, 0);
    @(negedge clk);

    // Grant withheld: 16 REQ cycles then a timeout pulse.
    applyStimulus(1'b0, 32'h100, 32'h0, 3'b010, 5'd4);
    reqCycles = 0;
    seenTimeout = 1'b0;
    for (int i = 0; i < 40 && !seenTimeout; i++) begin
      if (timeout) begin
        seenTimeout = 1'b1;
        checkOutput("to_req_drop", busReq, 0);
        checkOutput("to_stall", stall, 0);
        checkOutput("to_wb", wbEn, 0);
      end else begin
        if (busReq) reqCycles++;
        @(negedge clk);
      end
    end
    checkOutput("to_seen", seenTimeout, 1);
    checkOutput("to_req_cycles", reqCycles, 16);
    @(negedge clk);
    checkOutput("to_ready", ready, 1);
    checkOutput("to_pulse_end", timeout, 0);
    applyStimulus(1'b1, 32'h300, 32'hCAFEF00D, 3'b010, 5'd0);
    checkOutput("to_next_req", busReq, 1);
    checkOutput("to_next_wdata", busWdata, 32'hCAFEF00D);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    @(negedge clk);

    // Grant in the last permitted cycle beats the timeout.
    applyStimulus(1'b0, 32'h104, 32'h0, 3'b010, 5'd7);
    repeat (15) @(negedge clk);
    checkOutput("late_gnt_req", busReq, 1);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    checkOutput("late_gnt_to", timeout, 0);
    checkOutput("late_gnt_stall", stall, 1);
    busRvalid = 1'b1;
    busRdata  = 32'h12345678;
    @(negedge clk);
    busRvalid = 1'b0;
    checkOutput("late_gnt_wb", wbEn, 1);
    checkOutput("late_gnt_data", rdData, 32'h12345678);
    @(negedge clk);

    // Reset while waiting for read data.
    applyStimulus(1'b0, 32'h108, 32'h0, 3'b010, 5'd9);
    busGnt = 1'b1;
    @(negedge clk);
    busGnt = 1'b0;
    checkOutput("rr_stall_before", stall, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rr_req", busReq, 0);
    checkOutput("rr_ready", ready, 1);
    checkOutput("rr_stall", stall, 0);
    checkOutput("rr_wb", wbEn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busRvalid = 1'b1;
    busRdata  = 32'h0000FFFF;
    @(negedge clk);
    busRvalid = 1'b0;
    checkOutput("rr_late_wb", wbEn, 0);
    checkOutput("rr_late_ready", ready, 1);
    @(negedge clk);
    checkOutput("rr_late_wb2", wbEn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
